// File: rtl/nor_meter_pkg.sv
// Shared definitions for nor_activity_meter.
//   meter_state_e : measurement FSM encoding (IDLE=0, RUN=1, DONE=2)
//   sat_ovf       : 1 when acc + inc does not fit in `width` bits
//   sat_add       : acc + inc clamped to all-ones of `width` bits (width < 64)
package nor_meter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } meter_state_e;

    function automatic logic sat_ovf(input logic [63:0] acc, input logic [63:0] inc,
                                     input int unsigned width);
        logic [64:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return (sum >> width) != 65'd0;
    endfunction

    function automatic logic [63:0] sat_add(input logic [63:0] acc, input logic [63:0] inc,
                                            input int unsigned width);
        logic [63:0] mask;
        mask = (64'd1 << width) - 64'd1;
        if (sat_ovf(acc, inc, width)) begin
            return mask;
        end
        return acc + inc;
    endfunction

endpackage

// File: rtl/nor_activity_meter_if.sv
// Gate/metering bus of nor_activity_meter.
//   master : drives in_bits, meas_start, meas_stop, clr; observes the outputs
//   slave  : the meter; drives q, toggle_count, power_acc, cnt_sat, pwr_sat, running
interface nor_activity_meter_if #(
    parameter int unsigned N_INPUTS = 2,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned PWR_W    = 24
);
    logic [N_INPUTS-1:0] in_bits;
    logic                meas_start;
    logic                meas_stop;
    logic                clr;
    logic                q;
    logic [CNT_W-1:0]    toggle_count;
    logic [PWR_W-1:0]    power_acc;
    logic                cnt_sat;
    logic                pwr_sat;
    logic                running;

    modport master (
        output in_bits, meas_start, meas_stop, clr,
        input  q, toggle_count, power_acc, cnt_sat, pwr_sat, running
    );

    modport slave (
        input  in_bits, meas_start, meas_stop, clr,
        output q, toggle_count, power_acc, cnt_sat, pwr_sat, running
    );
endinterface

// File: rtl/nor_popcount.sv
// Number of set bits in i_bits.
//   i_bits  : N_INPUTS-bit vector
//   o_count : population count, $clog2(N_INPUTS+1) bits
module nor_popcount #(
    parameter int unsigned  N_INPUTS = 2,
    localparam int unsigned OUT_W    = $clog2(N_INPUTS + 1)
) (
    input  logic [N_INPUTS-1:0] i_bits,
    output logic [OUT_W-1:0]    o_count
);
    always_comb begin
        o_count = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            o_count = o_count + OUT_W'(i_bits[i]);
        end
    end
endmodule

// File: rtl/nor_activity_meter.sv
// N-input NOR gate with registered output and windowed switching-activity metering.
// Counts q transitions and charges E_OUT per q transition plus E_IN per toggling input bit,
// only while the measurement FSM is in RUN. Both accumulators saturate with sticky flags.
//   i_clk   : rising-edge clock
//   i_reset : synchronous active-high reset
//   io_bus  : nor_activity_meter_if slave (in_bits, meas_start/stop, clr in; q, counters out)
// Build option NOR_GLITCH_FILTER_EN: q only follows ~|in_bits once it has held for two
// consecutive edges (2-cycle latency, single-cycle pulses are swallowed).
module nor_activity_meter
    import nor_meter_pkg::*;
#(
    parameter int unsigned N_INPUTS = 2,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned PWR_W    = 24,
    parameter int unsigned E_OUT    = 8,
    parameter int unsigned E_IN     = 1
) (
    input logic                  i_clk,
    input logic                  i_reset,
    nor_activity_meter_if.slave  io_bus
);
    localparam int unsigned PC_W = $clog2(N_INPUTS + 1);

    meter_state_e        r_state;
    logic                r_running;
    logic                r_q;
    logic [N_INPUTS-1:0] r_in_prev;
    logic [CNT_W-1:0]    r_cnt;
    logic [PWR_W-1:0]    r_pwr;
    logic                r_cnt_sat;
    logic                r_pwr_sat;

    logic                w_nor;
    logic                w_q_d;
    logic                w_q_tog;
    logic [PC_W-1:0]     w_in_tog;
    logic                w_start;
    logic                w_stop;
    logic                w_count_en;
    logic [63:0]         w_pwr_inc;
    logic                w_cnt_ovf;
    logic                w_pwr_ovf;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [PWR_W-1:0]    w_pwr_next;

    assign w_nor = ~|io_bus.in_bits;

`ifdef NOR_GLITCH_FILTER_EN
    logic r_filt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_filt <= 1'b1;
        end else begin
            r_filt <= w_nor;
        end
    end

    // Accept a new gate value only once it matches the previous edge's sample.
    assign w_q_d = (w_nor == r_filt) ? w_nor : r_q;
`else
    assign w_q_d = w_nor;
`endif

    assign w_q_tog = w_q_d ^ r_q;

    nor_popcount #(
        .N_INPUTS (N_INPUTS)
    ) u_popcount (
        .i_bits  (io_bus.in_bits ^ r_in_prev),
        .o_count (w_in_tog)
    );

    // In RUN a simultaneous stop beats start; elsewhere start wins.
    assign w_start    = io_bus.meas_start && !(r_state == StRun && io_bus.meas_stop);
    assign w_stop     = io_bus.meas_stop && (r_state == StRun);
    assign w_count_en = (r_state == StRun) && !w_start;

    assign w_pwr_inc  = 64'(E_OUT) * 64'(w_q_tog) + 64'(E_IN) * 64'(w_in_tog);
    assign w_cnt_ovf  = sat_ovf(64'(r_cnt), 64'(w_q_tog), CNT_W);
    assign w_pwr_ovf  = sat_ovf(64'(r_pwr), w_pwr_inc, PWR_W);
    assign w_cnt_next = CNT_W'(sat_add(64'(r_cnt), 64'(w_q_tog), CNT_W));
    assign w_pwr_next = PWR_W'(sat_add(64'(r_pwr), w_pwr_inc, PWR_W));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_running <= 1'b0;
            r_q       <= 1'b1;
            r_in_prev <= '0;
            r_cnt     <= '0;
            r_pwr     <= '0;
            r_cnt_sat <= 1'b0;
            r_pwr_sat <= 1'b0;
        end else begin
            r_q       <= w_q_d;
            r_in_prev <= io_bus.in_bits;

            if (w_start) begin
                r_state   <= StRun;
                r_running <= 1'b1;
            end else if (w_stop) begin
                r_state   <= StDone;
                r_running <= 1'b0;
            end

            // Start and clr both zero the window; either overrides this edge's increment.
            if (w_start || io_bus.clr) begin
                r_cnt     <= '0;
                r_pwr     <= '0;
                r_cnt_sat <= 1'b0;
                r_pwr_sat <= 1'b0;
            end else if (w_count_en) begin
                r_cnt     <= w_cnt_next;
                r_pwr     <= w_pwr_next;
                r_cnt_sat <= r_cnt_sat | w_cnt_ovf;
                r_pwr_sat <= r_pwr_sat | w_pwr_ovf;
            end
        end
    end

    assign io_bus.q            = r_q;
    assign io_bus.toggle_count = r_cnt;
    assign io_bus.power_acc    = r_pwr;
    assign io_bus.cnt_sat      = r_cnt_sat;
    assign io_bus.pwr_sat      = r_pwr_sat;
    assign io_bus.running      = r_running;
endmodule
